memory_responder: RTL and testbench
===================================

// Module: memory_responder
// PURPOSE
//  Memory-side responder for the datapath's MAR/MDR memory port. Serves Read/Write
//  requests from the datapath control sequence: returns Mdatain into the MDR path and
//  stores MDR data on writes. Inserts a configurable number of wait states and signals
//  completion with MemReady. Sits between the datapath top and the board/simulation RAM.
// PARAMETERS
//  DATA_W       32   data word width (matches Mdatain / MDR)
//  ADDR_W       9    address width taken from MAR low bits
//  DEPTH        512  number of words in the internal array (<= 2**ADDR_W)
//  WAIT_CYCLES  1    wait states between request capture and response (0..15)
// PORTS
//  Clock     in   1       system clock, rising edge
//  Reset     in   1       synchronous, active-high reset
//  MARaddr   in   ADDR_W  word address from MAR
//  MDRdata   in   DATA_W  write data from MDR
//  Read      in   1       read request, level; held until MemReady seen
//  Write     in   1       write request, level; held until MemReady seen
//  Mdatain   out  DATA_W  read data to the MDR input mux, registered
//  MemReady  out  1       request complete; high while request held in RESP
//  MemErr    out  1       address fault (only with MEM_ERR_EN, else tied 0)
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE, counter=0, Mdatain=0, MemReady=0, MemErr=0.
//    Array contents are NOT cleared. Reset mid-request aborts it; a write not yet
//    committed is dropped.
//  - FSM: IDLE -> WAIT -> RESP -> IDLE.
//    IDLE: on an edge with Read|Write=1, capture MARaddr, MDRdata and op type;
//          go to WAIT (counter=WAIT_CYCLES), or straight to RESP when WAIT_CYCLES=0.
//    WAIT: decrement counter each edge; at 1 go to RESP. Request dropped during WAIT
//          returns to IDLE: no MemReady, no write.
//    RESP entry edge: read -> Mdatain<=mem[addr]; write -> mem[addr]<=data.
//          MemReady=1 from this edge onward.
//    RESP: hold while the captured request line stays high. When it drops, go to
//          IDLE on the next edge, with MemReady=0.
//  - Latency: request sampled at edge N -> MemReady high after edge N+WAIT_CYCLES+1.
//  - Captured address/data are frozen; later MAR/MDR changes are ignored for that request.
//  - Read and Write both high in IDLE: Read is served and Write is ignored.
//  - Back-to-back requests need Read/Write low for at least 1 edge (one IDLE cycle).
//  - Mdatain holds its last read value through IDLE and writes; only reads/reset change it.
//  - Address >= DEPTH without MEM_ERR_EN: index wraps modulo DEPTH (addr % DEPTH).
// CONFIGURATION
//  MEM_ERR_EN defined: address >= DEPTH completes with normal latency.
//    - Read returns Mdatain=32'hDEADBEEF (low DATA_W bits); write is suppressed.
//    - MemErr=1 for exactly the RESP entry cycle.
//  MEM_ERR_EN undefined: modulo wrap applies; MemErr is constant 0; no compare logic.
// TESTING
//  1 Reset, then Write addr 0x005, data 0x28918000; Read 0x005 -> Mdatain=0x28918000,
//    MemReady high after edge N+2 (WAIT_CYCLES=1).
//  2 WAIT_CYCLES=0: Read 0x005 -> MemReady after edge N+1; WAIT_CYCLES=3 -> after N+4.
//  3 Read and Write both high at addr 0x010 (holding 0x12), MDRdata=0x14
//    -> Mdatain=0x12, mem[0x010] still 0x12.
//  4 Write 0x18 to 0x020, drop Write during WAIT (WAIT_CYCLES=3)
//    -> no MemReady; later read of 0x020 returns old value.
//  5 Reset asserted in RESP -> MemReady=0, Mdatain=0 next edge; earlier writes survive.
//  6 DEPTH=256, read 0x105: with MEM_ERR_EN -> 0xDEADBEEF and a 1-cycle MemErr;
//    without it -> mem[0x005].

Source files
------------

// File: rtl/memory_responder_if.sv
// MAR/MDR memory port between the datapath (master) and the memory responder (slave).
// Read/Write are level requests: the master holds the request, along with MARaddr and
// MDRdata, until MemReady is seen. It then drops the request for at least one edge
// before issuing the next one. MemReady stays high while the request is still held.
interface memory_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic [ADDR_W-1:0] MARaddr;
  logic [DATA_W-1:0] MDRdata;
  logic              Read;
  logic              Write;
  logic [DATA_W-1:0] Mdatain;
  logic              MemReady;
  logic              MemErr;

  modport master (output MARaddr, MDRdata, Read, Write, input Mdatain, MemReady, MemErr);
  modport slave  (input MARaddr, MDRdata, Read, Write, output Mdatain, MemReady, MemErr);
endinterface

// File: rtl/memory_responder.sv
// Wait-state memory responder for the datapath MAR/MDR port (IDLE -> WAIT -> RESP).
// Optional feature macro: MEM_ERR_EN (out-of-range address fault instead of modulo wrap).
module memory_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  memory_responder_if.slave mem_if,
  output logic [1:0]        dbg_state
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              read_q, write_q;
  logic [ADDR_W-1:0] addr_in_q;
  logic [DATA_W-1:0] data_in_q;
  logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
  logic [DATA_W-1:0] cap_data_q, cap_data_d;
  logic              cap_rd_q, cap_rd_d;
  logic [DATA_W-1:0] mdatain_q, mdatain_d;
  logic              mem_ready_q, mem_ready_d;
  logic              held, enter_resp, mem_we;
  logic [31:0]       addr_ext;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  // The index follows the address being captured this edge, so the zero-wait path works.
  assign addr_ext = 32'(cap_addr_d);
  assign mem_idx  = IDX_W'(addr_ext % 32'(DEPTH));

`ifdef MEM_ERR_EN
  logic mem_err_q, mem_err_d, addr_fault;
  assign addr_fault = (addr_ext >= 32'(DEPTH));
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_addr_d = cap_addr_q;
    cap_data_d = cap_data_q;
    cap_rd_d   = cap_rd_q;
    mdatain_d  = mdatain_q;
    enter_resp = 1'b0;
    mem_we     = 1'b0;
`ifdef MEM_ERR_EN
    mem_err_d  = 1'b0;
`endif
    // Only the line that was captured keeps the request alive; Read wins a tie.
    held = cap_rd_q ? read_q : write_q;

    case (state_q)
      S_IDLE: begin
        if (read_q || write_q) begin
          cap_addr_d = addr_in_q;
          cap_data_d = data_in_q;
          cap_rd_d   = read_q;
          if (WAIT_CYCLES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        if (!held) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      S_RESP: begin
        if (!held) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_resp) begin
`ifdef MEM_ERR_EN
      if (addr_fault) begin
        mem_err_d = 1'b1;
        if (cap_rd_d) mdatain_d = DATA_W'(32'hDEADBEEF);
      end else begin
        if (cap_rd_d) mdatain_d = mem[mem_idx];
        else          mem_we    = !Reset;
      end
`else
      if (cap_rd_d) mdatain_d = mem[mem_idx];
      else          mem_we    = !Reset;
`endif
    end

    mem_ready_d = (state_d == S_RESP);
  end

  // Requests pass through one input register, giving the N+WAIT_CYCLES+1 latency.
  always_ff @(posedge Clock) begin
    addr_in_q <= mem_if.MARaddr;
    data_in_q <= mem_if.MDRdata;
    if (Reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      mdatain_q   <= '0;
      mem_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      read_q      <= mem_if.Read;
      write_q     <= mem_if.Write;
      cap_addr_q  <= cap_addr_d;
      cap_data_q  <= cap_data_d;
      cap_rd_q    <= cap_rd_d;
      mdatain_q   <= mdatain_d;
      mem_ready_q <= mem_ready_d;
    end
  end

`ifdef MEM_ERR_EN
  always_ff @(posedge Clock) begin
    if (Reset) mem_err_q <= 1'b0;
    else       mem_err_q <= mem_err_d;
  end
  assign mem_if.MemErr = mem_err_q;
`else
  assign mem_if.MemErr = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (mem_we) mem[mem_idx] <= cap_data_d;
  end

  assign mem_if.Mdatain  = mdatain_q;
  assign mem_if.MemReady = mem_ready_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: three instances (1, 0 and 3 wait states),
// a vector table of full transactions plus hand sequences for drop-in-WAIT and reset.
module tb_memory_responder;
  logic clk = 1'b0;
  logic Reset;
  logic [1:0] dbg_a, dbg_b, dbg_c;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  memory_responder_if #(.DATA_W(32), .ADDR_W(9)) if_a ();
  memory_responder_if #(.DATA_W(32), .ADDR_W(9)) if_b ();
  memory_responder_if #(.DATA_W(32), .ADDR_W(9)) if_c ();

  memory_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_CYCLES(1)) dut_a (
    .Clock(clk), .Reset(Reset), .mem_if(if_a), .dbg_state(dbg_a));
  memory_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_CYCLES(0)) dut_b (
    .Clock(clk), .Reset(Reset), .mem_if(if_b), .dbg_state(dbg_b));
  memory_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH(256), .WAIT_CYCLES(3)) dut_c (
    .Clock(clk), .Reset(Reset), .mem_if(if_c), .dbg_state(dbg_c));

`ifdef MEM_ERR_EN
  localparam logic [31:0] ERR_RD = 32'hDEADBEEF;
  localparam int          ERR_N  = 1;
  localparam logic [31:0] POST   = 32'h5555_0005;
`else
  localparam logic [31:0] ERR_RD = 32'h5555_0005;
  localparam int          ERR_N  = 0;
  localparam logic [31:0] POST   = 32'h0000_0077;
`endif

  typedef struct {
    int          sel;
    logic        rd;
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] wdata;
    int          lat;
    logic        chk;
    logic [31:0] rdata;
    int          errs;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int sel, logic rd, logic wr, logic [8:0] addr, logic [31:0] wdata,
                              int lat, logic chk, logic [31:0] rdata, int errs);
    vec_t v;
    v.sel = sel; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.lat = lat; v.chk = chk; v.rdata = rdata; v.errs = errs;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [8:0] a, input logic [31:0] d);
    case (sel)
      0: begin if_a.Read = rd; if_a.Write = wr; if_a.MARaddr = a; if_a.MDRdata = d; end
      1: begin if_b.Read = rd; if_b.Write = wr; if_b.MARaddr = a; if_b.MDRdata = d; end
      default: begin if_c.Read = rd; if_c.Write = wr; if_c.MARaddr = a; if_c.MDRdata = d; end
    endcase
  endtask

  task automatic sample(input int sel, output logic r, output logic e,
                        output logic [31:0] q, output logic [1:0] st);
    case (sel)
      0: begin r = if_a.MemReady; e = if_a.MemErr; q = if_a.Mdatain; st = dbg_a; end
      1: begin r = if_b.MemReady; e = if_b.MemErr; q = if_b.Mdatain; st = dbg_b; end
      default: begin r = if_c.MemReady; e = if_c.MemErr; q = if_c.Mdatain; st = dbg_c; end
    endcase
  endtask

  // Starts and ends on a negedge. lat counts edges after the sampling edge N.
  task automatic run_txn(input int sel, input logic rd, input logic wr,
                         input logic [8:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] dout,
                         output int errs, output logic rdy_after);
    logic r, e;
    logic [31:0] q;
    logic [1:0] st;
    lat = -1;
    errs = 0;
    drive(sel, rd, wr, a, d);
    @(posedge clk);
    #1 drive(sel, rd, wr, ~a, ~d);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      sample(sel, r, e, q, st);
      if (e) errs++;
      if (r) begin
        lat = k;
        break;
      end
      @(posedge clk);
    end
    if (lat < 0) @(negedge clk);
    dout = q;
    drive(sel, 1'b0, 1'b0, a, d);
    r = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      sample(sel, r, e, q, st);
      if (e) errs++;
    end
    rdy_after = r;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, errs;
    logic [31:0] dout;
    logic rdy_after, r, e, seen;
    logic [31:0] q;
    logic [1:0] st;

    vecs.push_back(mk(0, 1'b0, 1'b1, 9'h005, 32'h2891_8000, 2, 1'b0, 32'h0, 0));
    vecs.push_back(mk(0, 1'b1, 1'b0, 9'h005, 32'h0,         2, 1'b1, 32'h2891_8000, 0));
    vecs.push_back(mk(0, 1'b0, 1'b1, 9'h010, 32'h0000_0012, 2, 1'b0, 32'h0, 0));
    vecs.push_back(mk(0, 1'b1, 1'b1, 9'h010, 32'h0000_0014, 2, 1'b1, 32'h0000_0012, 0));
    vecs.push_back(mk(0, 1'b1, 1'b0, 9'h010, 32'h0,         2, 1'b1, 32'h0000_0012, 0));
    vecs.push_back(mk(1, 1'b0, 1'b1, 9'h005, 32'hA5A5_0005, 1, 1'b0, 32'h0, 0));
    vecs.push_back(mk(1, 1'b1, 1'b0, 9'h005, 32'h0,         1, 1'b1, 32'hA5A5_0005, 0));
    vecs.push_back(mk(2, 1'b0, 1'b1, 9'h020, 32'h0000_0011, 4, 1'b0, 32'h0, 0));
    vecs.push_back(mk(2, 1'b0, 1'b1, 9'h005, 32'h5555_0005, 4, 1'b0, 32'h0, 0));
    vecs.push_back(mk(2, 1'b1, 1'b0, 9'h005, 32'h0,         4, 1'b1, 32'h5555_0005, 0));
    vecs.push_back(mk(2, 1'b1, 1'b0, 9'h105, 32'h0,         4, 1'b1, ERR_RD, ERR_N));
    vecs.push_back(mk(2, 1'b0, 1'b1, 9'h105, 32'h0000_0077, 4, 1'b1, ERR_RD, ERR_N));
    vecs.push_back(mk(2, 1'b1, 1'b0, 9'h005, 32'h0,         4, 1'b1, POST, 0));

    // clock/reset
    Reset = 1'b1;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, 9'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    Reset = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sample(s, r, e, q, st);
      check($sformatf("reset_ready[%0d]", s), 32'(r), 32'h0);
      check($sformatf("reset_err[%0d]", s), 32'(e), 32'h0);
      check($sformatf("reset_mdatain[%0d]", s), q, 32'h0);
      check($sformatf("reset_state[%0d]", s), 32'(st), 32'h0);
    end
    @(negedge clk);

    foreach (vecs[i]) begin
      run_txn(vecs[i].sel, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
              lat, dout, errs, rdy_after);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      if (vecs[i].chk) check($sformatf("vec%0d_mdatain", i), dout, vecs[i].rdata);
      check($sformatf("vec%0d_memerr_cycles", i), 32'(errs), 32'(vecs[i].errs));
      check($sformatf("vec%0d_ready_released", i), 32'(rdy_after), 32'h0);
    end

    // Write dropped during WAIT on the 3-wait-state instance.
    drive(2, 1'b0, 1'b1, 9'h020, 32'h0000_0018);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    sample(2, r, e, q, st);
    check("drop_in_wait_state", 32'(st), 32'h1);
    drive(2, 1'b0, 1'b0, 9'h020, 32'h0000_0018);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      sample(2, r, e, q, st);
      if (r) seen = 1'b1;
    end
    check("drop_no_ready", 32'(seen), 32'h0);
    check("drop_back_idle", 32'(st), 32'h0);
    run_txn(2, 1'b1, 1'b0, 9'h020, 32'h0, lat, dout, errs, rdy_after);
    check("drop_readback", dout, 32'h0000_0011);
    check("drop_readback_latency", 32'(lat), 32'd4);

    // Reset while a read sits in RESP.
    drive(0, 1'b1, 1'b0, 9'h005, 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      sample(0, r, e, q, st);
      if (r) seen = 1'b1;
    end
    check("rst_resp_reached", 32'(seen), 32'h1);
    check("rst_resp_data", q, 32'h2891_8000);
    Reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Reset = 1'b0;
    drive(0, 1'b0, 1'b0, 9'h005, 32'h0);
    sample(0, r, e, q, st);
    check("rst_resp_ready", 32'(r), 32'h0);
    check("rst_resp_mdatain", q, 32'h0);
    check("rst_resp_state", 32'(st), 32'h0);
    @(negedge clk);

    // Reset while a write waits: the write must not land.
    drive(0, 1'b0, 1'b1, 9'h005, 32'hBAD0_BAD0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    sample(0, r, e, q, st);
    check("rst_wait_state", 32'(st), 32'h1);
    Reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Reset = 1'b0;
    drive(0, 1'b0, 1'b0, 9'h005, 32'h0);
    @(negedge clk);
    run_txn(0, 1'b1, 1'b0, 9'h005, 32'h0, lat, dout, errs, rdy_after);
    check("rst_survive_data", dout, 32'h2891_8000);
    check("rst_survive_latency", 32'(lat), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
